// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX operand staging register.
// Builds the ALU lhs/rhs operands from the decoded selects and the register and
// instruction fields, then registers them toward execute. Both sides use a
// valid/ready handshake. A one-entry skid buffer lets o_ready come straight from
// a flop, so it never depends combinationally on i_ready. Flush squashes all
// held sets and the set offered in the flush cycle.
module alu_operand_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              w_alu_lhs_ctrl,
    input  logic [1:0]        w_alu_rhs_ctrl,
    input  logic [DATA_W-1:0] w_rs_data,
    input  logic [DATA_W-1:0] w_rt_data,
    input  logic [15:0]       w_imm16,
    input  logic [4:0]        w_shamt,
    input  logic              w_imm_sext,
    input  logic              w_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] w_alu_lhs,
    output logic [DATA_W-1:0] w_alu_rhs
);

    typedef struct packed {
        logic [DATA_W-1:0] lhs;
        logic [DATA_W-1:0] rhs;
    } opset_t;

    opset_t new_set;
    opset_t out_q, out_d;
    opset_t skid_q, skid_d;
    logic   out_vld_q, out_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   rdy_q;
    logic   accept;
    logic   drain;

    // Handshake terms. Acceptance is qualified by the registered ready, so a
    // full skid buffer blocks new sets.
    assign accept = i_valid & rdy_q & ~w_flush;
    assign drain  = out_vld_q & i_ready;

    // Build the operand set from this cycle's inputs. Nothing is re-sampled later.
    always_comb begin
        new_set.lhs = w_alu_lhs_ctrl ? w_rt_data : w_rs_data;
        unique case (w_alu_rhs_ctrl)
            2'b00:   new_set.rhs = {{(DATA_W-5){1'b0}}, w_rs_data[4:0]};
            2'b01:   new_set.rhs = w_rt_data;
            2'b10:   new_set.rhs = {{(DATA_W-5){1'b0}}, w_shamt};
            default: new_set.rhs = w_imm_sext ? {{(DATA_W-16){w_imm16[15]}}, w_imm16}
                                              : {{(DATA_W-16){1'b0}}, w_imm16};
        endcase
    end

    // Next-state of the output register and skid buffer. Skid contents always
    // move to the output ahead of a newly accepted set, which keeps delivery FIFO.
    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (w_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || drain) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = accept;
                if (accept) skid_d = new_set;
            end else if (accept) begin
                out_d     = new_set;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = new_set;
            skid_vld_d = 1'b1;
        end
    end

    // State registers. Ready is held low while reset is asserted and follows
    // the inverted next skid state afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign o_ready   = rdy_q;
    assign o_valid   = out_vld_q;
    assign w_alu_lhs = out_q.lhs;
    assign w_alu_rhs = out_q.rhs;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: the driver pushes expected operand sets into a
// scoreboard queue on every accept, and a separate monitor pops and compares
// on every output transfer. Directed cases come first, then a random phase.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_valid, o_ready, o_valid, i_ready, w_flush;
    logic        w_alu_lhs_ctrl, w_imm_sext;
    logic [1:0]  w_alu_rhs_ctrl;
    logic [31:0] w_rs_data, w_rt_data, w_alu_lhs, w_alu_rhs;
    logic [15:0] w_imm16;
    logic [4:0]  w_shamt;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
    } ops_t;

    ops_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    alu_operand_stage #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .w_alu_lhs_ctrl(w_alu_lhs_ctrl), .w_alu_rhs_ctrl(w_alu_rhs_ctrl),
        .w_rs_data(w_rs_data), .w_rt_data(w_rt_data), .w_imm16(w_imm16),
        .w_shamt(w_shamt), .w_imm_sext(w_imm_sext), .w_flush(w_flush),
        .o_valid(o_valid), .i_ready(i_ready),
        .w_alu_lhs(w_alu_lhs), .w_alu_rhs(w_alu_rhs)
    );

    // Reference operand formation written from the select table with plain arithmetic.
    function automatic ops_t ref_ops();
        ops_t r;
        longint unsigned imm;
        r.lhs = (w_alu_lhs_ctrl == 1'b1) ? w_rt_data : w_rs_data;
        imm = longint'(w_imm16);
        if (w_imm_sext && imm >= 32768) imm = imm + 64'hFFFF_0000;
        case (int'(w_alu_rhs_ctrl))
            0:       r.rhs = w_rs_data % 32;
            1:       r.rhs = w_rt_data;
            2:       r.rhs = 32'(w_shamt);
            default: r.rhs = imm[31:0];
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rand_fields();
        w_alu_lhs_ctrl = 1'($urandom_range(0, 1));
        w_alu_rhs_ctrl = 2'($urandom_range(0, 3));
        w_rs_data      = $urandom;
        w_rt_data      = $urandom;
        w_imm16        = 16'($urandom);
        w_shamt        = 5'($urandom);
        w_imm_sext     = 1'($urandom_range(0, 1));
    endtask

    // Apply inputs just after an edge, record the expected set if it will be
    // accepted at the coming edge, then return just after that edge.
    task automatic step(input bit v, input bit r, input bit f);
        i_valid = v;
        i_ready = r;
        w_flush = f;
        if (reset || f) exp_q.delete();
        else if (v && o_ready) exp_q.push_back(ref_ops());
        @(posedge clock);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest outstanding set.
    always @(negedge clock) begin
        ops_t e;
        if (!reset && !w_flush && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got lhs %h rhs %h expected nothing", w_alu_lhs, w_alu_rhs);
            end else begin
                e = exp_q.pop_front();
                chk("sb_lhs", w_alu_lhs, e.lhs);
                chk("sb_rhs", w_alu_rhs, e.rhs);
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_valid = 1'b0; i_ready = 1'b0; w_flush = 1'b0;
        w_alu_lhs_ctrl = 1'b0; w_alu_rhs_ctrl = 2'b00; w_rs_data = '0; w_rt_data = '0;
        w_imm16 = '0; w_shamt = '0; w_imm_sext = 1'b0;
        @(posedge clock);
        #1;
        step(1, 1, 0);
        step(1, 1, 0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_lhs", w_alu_lhs, 32'd0);
        chk("rst_rhs", w_alu_rhs, 32'd0);
        reset = 1'b0;
        step(0, 1, 0);
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // Immediate, sign- and zero-extended.
        w_alu_lhs_ctrl = 1'b0; w_alu_rhs_ctrl = 2'b11; w_rs_data = 32'h0000_0010;
        w_imm16 = 16'h8000; w_imm_sext = 1'b1;
        step(1, 1, 0);
        chk("imm_valid", 32'(o_valid), 32'd1);
        chk("imm_lhs", w_alu_lhs, 32'h0000_0010);
        chk("imm_sext_rhs", w_alu_rhs, 32'hFFFF_8000);
        w_imm_sext = 1'b0;
        step(1, 1, 0);
        chk("imm_zext_rhs", w_alu_rhs, 32'h0000_8000);

        // Shift selects.
        w_alu_lhs_ctrl = 1'b1; w_alu_rhs_ctrl = 2'b10; w_rt_data = 32'hA5A5_A5A5; w_shamt = 5'd7;
        step(1, 1, 0);
        chk("shamt_lhs", w_alu_lhs, 32'hA5A5_A5A5);
        chk("shamt_rhs", w_alu_rhs, 32'h0000_0007);
        w_alu_rhs_ctrl = 2'b00; w_rs_data = 32'hFFFF_FFE3;
        step(1, 1, 0);
        chk("varshift_rhs", w_alu_rhs, 32'h0000_0003);
        step(0, 1, 0);

        // Back-pressure: A held, B in skid, C refused until the pipe drains.
        rand_fields(); step(1, 0, 0);
        chk("bp_a_ready", 32'(o_ready), 32'd1);
        rand_fields(); step(1, 0, 0);
        chk("bp_b_ready", 32'(o_ready), 32'd0);
        rand_fields(); step(1, 0, 0);
        chk("bp_c_refused", 32'(exp_q.size()), 32'd2);
        step(1, 1, 0);
        chk("bp_ready_back", 32'(o_ready), 32'd1);
        step(1, 1, 0);
        step(0, 1, 0);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full throughput.
        for (int i = 0; i < 8; i++) begin
            chk("tp_ready", 32'(o_ready), 32'd1);
            rand_fields();
            step(1, 1, 0);
            chk("tp_valid", 32'(o_valid), 32'd1);
        end
        step(0, 1, 0);

        // Flush with output and skid full, plus a set offered in the flush cycle.
        rand_fields(); step(1, 0, 0);
        rand_fields(); step(1, 0, 0);
        chk("fl_full_ready", 32'(o_ready), 32'd0);
        rand_fields(); step(1, 1, 1);
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ready", 32'(o_ready), 32'd1);
        step(0, 1, 0);
        chk("fl_no_ghost", 32'(o_valid), 32'd0);

        // Reset mid-stream with the skid full.
        rand_fields(); step(1, 0, 0);
        rand_fields(); step(1, 0, 0);
        reset = 1'b1;
        rand_fields(); step(1, 1, 0);
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_lhs", w_alu_lhs, 32'd0);
        chk("mrst_rhs", w_alu_rhs, 32'd0);
        reset = 1'b0;
        step(0, 1, 0);
        chk("mrst_ready", 32'(o_ready), 32'd1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
        end
        repeat (3) step(0, 1, 0);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX operand staging block. It consumes the decoded ALU operand selects (w_alu_lhs_ctrl, w_alu_rhs_ctrl) together with the register-file and instruction fields.
- It forms the 32-bit ALU lhs/rhs operands and registers them into the execute stage.
- Transfers on both sides use a valid/ready handshake. A one-entry skid buffer keeps o_ready a pure register output.
- Flush support covers branch and jump squash.

Parameters:
- DATA_W, 32, operand width. Only 32 is supported.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  upstream offers an operand set
- o_ready  out  1  stage can accept an operand set this cycle
- w_alu_lhs_ctrl  in  1  0: lhs=rs, 1: lhs=rt (shift source)
- w_alu_rhs_ctrl  in  2  00: rs[4:0] shift amount, 01: rt, 10: shamt, 11: immediate
- w_rs_data  in  32  rs register value
- w_rt_data  in  32  rt register value
- w_imm16  in  16  instruction immediate
- w_shamt  in  5  instruction shamt field
- w_imm_sext  in  1  1: sign-extend immediate, 0: zero-extend
- w_flush  in  1  squash all held and incoming operand sets
- o_valid  out  1  w_alu_lhs/w_alu_rhs hold a valid operand set
- i_ready  in  1  execute stage consumes the operand set
- w_alu_lhs  out  32  registered ALU left operand
- w_alu_rhs  out  32  registered ALU right operand

Behaviour:
- Reset (synchronous, active-high): o_valid=0, skid valid=0, w_alu_lhs=0, w_alu_rhs=0, skid data=0. o_ready=1 from the first edge after reset deasserts; while reset is held, nothing is accepted.
- o_ready equals ~skid_valid, a registered value; it has no combinational path from i_ready.
- Accept condition: i_valid & o_ready & ~w_flush. Operands are formed combinationally from the inputs in the accept cycle and are never re-sampled later.
- Operand formation:
  - lhs = w_alu_lhs_ctrl ? w_rt_data : w_rs_data.
  - rhs for 00 = {27'b0, w_rs_data[4:0]} (variable shift).
  - rhs for 01 = w_rt_data.
  - rhs for 10 = {27'b0, w_shamt}.
  - rhs for 11 = w_imm_sext ? {{16{w_imm16[15]}}, w_imm16} : {16'b0, w_imm16}.
- Output drain: when o_valid & i_ready, the output register is consumed.
- Per-edge update, when not flushing:
  - Output empty or draining: output loads skid data if skid valid (skid clears), else the accepted set, else o_valid goes to 0.
  - Output full and not draining: an accepted set goes into the skid buffer. Acceptance is only possible while skid is empty.
  - Skid valid and output draining with a simultaneous accept: skid moves to the output, the new set moves into skid, and skid stays valid.
- Latency: 1 cycle from accept to o_valid when the pipe is empty. Throughput is 1 set per cycle while i_ready=1.
- Ordering: strictly FIFO; no set is dropped or duplicated except under flush.
- Flush: on the w_flush edge, o_valid=0 and skid valid=0. The input offered in that cycle is discarded and o_ready=1 next cycle. Data registers may keep stale values.
- Flush with simultaneous i_ready: flush wins; the consumer must ignore the set.
- Reset during operation: reset overrides flush and all transfers. All state returns to reset values on the same edge.
- w_alu_lhs/w_alu_rhs are stable whenever o_valid=1 & i_ready=0.

Test Plan:
- Reset, then i_valid=1, lhs_ctrl=0, rhs_ctrl=11, rs=0x00000010, imm16=0x8000, sext=1 -> next cycle o_valid=1, lhs=0x00000010, rhs=0xFFFF8000. Same with sext=0 -> rhs=0x00008000.
- Shift selects: lhs_ctrl=1, rhs_ctrl=10, rt=0xA5A5A5A5, shamt=7 -> lhs=0xA5A5A5A5, rhs=0x00000007. rhs_ctrl=00, rs=0xFFFFFFE3 -> rhs=0x00000003.
- Back-pressure: i_ready=0, stream sets A, B, C -> A held at output, B in skid, o_ready=0 the cycle after B is accepted, C not accepted. i_ready=1 -> A, B, C delivered in order, one per cycle.
- Full throughput: i_ready=1, 8 consecutive sets -> 8 outputs on consecutive cycles, o_ready never drops.
- Flush with output and skid both full -> next cycle o_valid=0, o_ready=1. A set offered with w_flush=1 never appears at the output.
- Reset asserted mid-stream with skid full -> next cycle o_valid=0, operands=0, o_ready=1 once reset deasserts.
